rr_mux: RTL and testbench
=========================

Name: rr_mux

Overview:
Parametrised N-channel, W-bit multiplexer with per-channel valid/ready handshakes and a registered output stage. It generalises the 2:1 select mux: with force_en=1 it behaves as an explicit-select mux; otherwise a round-robin arbiter picks among valid inputs. It sits between multiple producers and a single consumer, for example stream merging ahead of a shared datapath.

Parameters:
N, 4, number of input channels (2..16)
W, 8, data width per channel (>=1)
SW, $clog2(N), width of the channel index (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_valid  input  N  per-channel data valid
in_ready  output  N  per-channel accept; combinational
force_en  input  1  1 = explicit select mode; 0 = arbitration
force_sel  input  SW  channel index used when force_en=1
out_data  output  W  registered selected data
out_chan  output  SW  registered index of the channel that supplied out_data
out_valid  output  1  registered output valid
out_ready  input  1  consumer accept

Behaviour:
- Reset (synchronous, takes priority over all else): out_valid=0, out_data=0, out_chan=0, rr_ptr=0.
- load = !out_valid || out_ready. The single output register accepts a new word whenever it is empty or being drained in the same cycle. This gives full throughput of 1 word/cycle.
- Candidate set:
  - force_en=1: only channel force_sel. If force_sel >= N, the set is empty.
  - force_en=0: all i with in_valid[i]=1.
- Grant:
  - Round-robin: the first candidate at or after rr_ptr, wrapping N-1 -> 0.
  - Forced mode: the grant is force_sel if that channel is valid.
- in_ready[i] = load && (grant exists) && (grant==i). At most one bit is set. in_ready never depends on in_valid[i] of any other channel except through grant selection.
- On a transfer (in_valid[g] && in_ready[g]):
  - out_data <= in_data[g], out_chan <= g, out_valid <= 1.
  - rr_ptr <= (g+1) mod N, in both modes.
- If load and no grant: out_valid <= 0 on the next edge; out_data and out_chan hold their last values.
- If out_valid && !out_ready: out_data, out_chan and out_valid hold, and all in_ready are 0.
- Latency: 1 cycle from input handshake to out_valid.
- Simultaneous drain and refill in one cycle is legal; there is no bubble.
- Mode switch: force_en and force_sel are sampled each cycle. A change while the output is stalled has no effect on the held word.
- Reset mid-transfer: the held word is discarded, and no in_ready is asserted in the reset cycle.
- Inputs must hold in_data/in_valid stable until accepted. This is a bench check, not an RTL check.

Optional Feature:
RR_MUX_LOCK_EN
- Defined: adds input port in_last [N]. Once channel g transfers with in_last[g]=0, the grant is locked to g, ignoring other channels and force_en. The lock releases after the transfer with in_last[g]=1, so multi-beat packets stay contiguous. Reset clears the lock.
- Undefined: port absent, and every beat is arbitrated independently.

Decomposition:
- Package rr_mux_pkg holds the clog2-based index-width helper function and the reset constants (RST_PTR=0).
- Sub-module rr_arbiter (parameter N) contains only combinational logic: req[N] and ptr[SW] in, gnt_valid and gnt_idx out. It is reused by the top for both modes, with req masked to one-hot in forced mode.

Test Plan:
- Reset, then all in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=0000.
- N=4, W=8, all valid, data 0x10/0x11/0x12/0x13, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, one word per cycle.
- force_en=1, force_sel=2, all valid -> only in_ready[2] pulses, and out_data=0x12 every cycle. Then force_sel=1 with in_valid[1]=0 -> out_valid=0 the next cycle.
- out_ready=0 for 3 cycles with out_valid=1 -> out_data, out_chan and out_valid stable, and in_ready=0000 throughout. Release -> the next word is loaded in the same cycle as the drain.
- Only channels 1 and 3 valid, rr_ptr=2 -> grant 3, then 1, then 3.
- Assert rst while out_valid=1 and out_ready=0 -> out_valid=0 after the edge, rr_ptr=0, and the first grant after reset goes to the lowest valid channel.

Source files
------------

// File: rtl/rr_mux_pkg.sv
// Shared helpers and reset constants for the rr_mux round-robin multiplexer.
package rr_mux_pkg;

  // Value loaded into the round-robin pointer on reset.
  localparam int RST_PTR = 0;

  // Width of a channel index for n channels. Never less than one bit.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Purely combinational round-robin arbiter. It grants the first requester at
// or after ptr, wrapping from N-1 back to 0.
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int SW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt_idx
);

  logic [SW:0]   sum;
  logic [SW-1:0] cand;

  // Scan the channels starting at ptr and keep the first requester found.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      sum       = {1'b0, ptr} + (SW+1)'(k);
      sum       = (sum >= (SW+1)'(N)) ? (sum - (SW+1)'(N)) : sum;
      cand      = sum[SW-1:0];
      gnt_idx   = (req[cand] && !gnt_valid) ? cand : gnt_idx;
      gnt_valid = gnt_valid | req[cand];
    end
  end

endmodule

// File: rtl/rr_mux.sv
// N-channel, W-bit valid/ready multiplexer with a registered output stage.
// When force_en=1 the mux uses force_sel to choose the channel. Otherwise a
// round-robin arbiter picks among the valid channels.
// Optional feature macro: RR_MUX_LOCK_EN. It adds in_last[N], which keeps
// the grant on one channel until that channel sends the final beat of its
// packet.
module rr_mux
  import rr_mux_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = idx_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [N-1:0]   in_last,
`endif
  input  logic           force_en,
  input  logic [SW-1:0]  force_sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] rr_ptr;
  logic [N-1:0]  req;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic          load;
  logic          fsel_ok;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] nxt_ptr;

`ifdef RR_MUX_LOCK_EN
  logic          lock_active;
  logic [SW-1:0] lock_chan;
`endif

  // The output register accepts a new word when it is empty or being drained.
  assign load    = !out_valid || out_ready;
  assign fsel_ok = ({1'b0, force_sel} < (SW+1)'(N));
  assign nxt_ptr = (gnt_idx == SW'(N-1)) ? '0 : (gnt_idx + SW'(1));

  // Build the candidate set for the current mode. In forced mode it is one-hot.
  always_comb begin
    req = '0;
`ifdef RR_MUX_LOCK_EN
    if (lock_active) begin
      req[lock_chan] = in_valid[lock_chan];
    end else
`endif
    if (force_en) begin
      if (fsel_ok) begin
        req[force_sel] = in_valid[force_sel];
      end else begin
        req = '0;
      end
    end else begin
      req = in_valid;
    end
  end

  rr_arbiter #(.N(N)) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Route the granted channel's data to the output register input.
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      sel_data = (gnt_idx == SW'(i)) ? in_data[i*W +: W] : sel_data;
    end
  end

  // Accept from the granted channel only. Nothing is accepted during reset.
  always_comb begin
    in_ready = '0;
    if (!rst && load && gnt_valid) begin
      in_ready[gnt_idx] = 1'b1;
    end else begin
      in_ready = '0;
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= SW'(RST_PTR);
    end else if (load) begin
      if (gnt_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_chan  <= gnt_idx;
        rr_ptr    <= nxt_ptr;
      end else begin
        out_valid <= 1'b0;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

`ifdef RR_MUX_LOCK_EN
  // Keep the grant on a channel until it transfers a beat marked last.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_active <= 1'b0;
      lock_chan   <= '0;
    end else if (load && gnt_valid) begin
      lock_active <= !in_last[gnt_idx];
      lock_chan   <= gnt_idx;
    end else begin
      lock_active <= lock_active;
    end
  end
`endif

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (N=4, W=8). It applies a table of directed
// vectors and then randomized traffic checked against a behavioural model.
module tb_rr_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic         force_en;
  logic [1:0]   force_sel;
  logic [W-1:0] out_data;
  logic [1:0]   out_chan;
  logic         out_valid;
  logic         out_ready;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0] in_last = '1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_MUX_LOCK_EN
    .in_last   (in_last),
`endif
    .force_en  (force_en),
    .force_sel (force_sel),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       fen;
    logic [1:0] fsel;
    logic       ordy;
    logic [3:0] e_rdy;
    logic       e_ov;
    logic [1:0] e_ch;
    logic [7:0] e_d;
  } vec_t;

  vec_t tbl[23];

  // Behavioural model state.
  bit         m_ov;
  logic [7:0] m_d;
  int         m_ch;
  int         m_ptr;
  logic [7:0] chan_data [N];

  function automatic int model_grant(input logic [3:0] vld, input logic fen, input logic [1:0] fsel);
    if (fen) begin
      return (int'(fsel) < N && vld[fsel]) ? int'(fsel) : -1;
    end
    for (int k = 0; k < N; k++) begin
      if (vld[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  initial begin
    // rst vld fen fsel ordy | rdy ov ch data
    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[1]  = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[6]  = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[7]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[8]  = '{1'b0, 4'b1111, 1'b1, 2'd2, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[9]  = '{1'b0, 4'b1101, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h12};
    tbl[10] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[11] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13};
    tbl[12] = '{1'b0, 4'b1111, 1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13};
    tbl[13] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h13};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    tbl[15] = '{1'b0, 4'b0010, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[16] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[17] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    tbl[18] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    tbl[19] = '{1'b0, 4'b0100, 1'b0, 2'd0, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    tbl[20] = '{1'b0, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b1, 2'd2, 8'h12};
    tbl[21] = '{1'b1, 4'b1111, 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h00};
    tbl[22] = '{1'b0, 4'b1010, 1'b0, 2'd0, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};

    rst       = 1'b1;
    in_valid  = '0;
    force_en  = 1'b0;
    force_sel = '0;
    out_ready = 1'b1;
    in_data   = {8'h13, 8'h12, 8'h11, 8'h10};

    // Directed vectors: in_ready before the edge, then output registers after it.
    for (int i = 0; i < 23; i++) begin
      rst       = tbl[i].rst;
      in_valid  = tbl[i].vld;
      force_en  = tbl[i].fen;
      force_sel = tbl[i].fsel;
      out_ready = tbl[i].ordy;
      #2;
      chk("in_ready", i, 32'(in_ready), 32'(tbl[i].e_rdy));
      @(posedge clk);
      #1;
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].e_ov));
      chk("out_chan", i, 32'(out_chan), 32'(tbl[i].e_ch));
      chk("out_data", i, 32'(out_data), 32'(tbl[i].e_d));
    end

    // Randomized traffic against the model. Start from a reset cycle.
    m_ov  = 1'b0;
    m_d   = 8'h00;
    m_ch  = 0;
    m_ptr = 0;
    in_valid = '0;
    for (int c = 0; c < N; c++) chan_data[c] = 8'($urandom);
    for (int t = 0; t < 400; t++) begin
      int g;
      bit ld;
      logic [3:0] e_rdy;
      rst       = (t == 0) || ($urandom_range(0, 49) == 0);
      force_en  = ($urandom_range(0, 3) == 0);
      force_sel = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) in_data[c*W +: W] = chan_data[c];
      #2;
      ld    = !m_ov || out_ready;
      g     = model_grant(in_valid, force_en, force_sel);
      e_rdy = (!rst && ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rnd_in_ready", t, 32'(in_ready), 32'(e_rdy));
      @(posedge clk);
      if (rst) begin
        m_ov = 1'b0; m_d = 8'h00; m_ch = 0; m_ptr = 0;
      end else if (ld) begin
        if (g >= 0) begin
          m_ov = 1'b1; m_d = chan_data[g]; m_ch = g; m_ptr = (g + 1) % N;
        end else begin
          m_ov = 1'b0;
        end
      end
      #1;
      chk("rnd_out_valid", t, 32'(out_valid), 32'(m_ov));
      chk("rnd_out_chan", t, 32'(out_chan), 32'(m_ch));
      chk("rnd_out_data", t, 32'(out_data), 32'(m_d));
      // Producers hold a pending word until it is accepted.
      for (int c = 0; c < N; c++) begin
        if (!in_valid[c] || e_rdy[c]) begin
          in_valid[c]  = ($urandom_range(0, 2) != 0);
          chan_data[c] = 8'($urandom);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
